// File: rtl/lcm_if.sv
// Operand/result bundle for the sequential LCM engine.
interface lcm_if #(parameter int N = 8);
  logic           start;
  logic [N-1:0]   in1;
  logic [N-1:0]   in2;
  logic [2*N-1:0] lcm;
  logic           done;
  logic           busy;

  modport master (output start, in1, in2, input lcm, done, busy);
  modport slave  (input start, in1, in2, output lcm, done, busy);
endinterface

// File: rtl/lcm_seq.sv
// Sequential LCM: Euclid GCD, restoring division in1/g, then shift-and-add q*in2.
module lcm_seq #(
  parameter int N = 8
) (
  input logic  clk,
  input logic  rst,
  lcm_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {IDLE, GCD, DIV, MUL, FIN} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   op1, op2, a, b, g, rem, dvd, q, mplier;
  logic [2*N-1:0] mcand, acc;
  logic [CW-1:0]  cnt;

  logic [N:0]     trial;
  logic [N-1:0]   diff, q_nxt;
  logic           qbit, last;
  logic [2*N-1:0] acc_nxt;

  // trial fits in N+1 bits because rem < g; after subtraction the result is < g again
  always_comb begin
    trial   = {rem, dvd[N-1]};
    qbit    = (trial >= {1'b0, g});
    diff    = trial[N-1:0] - g;
    q_nxt   = (q << 1) | {{(N-1){1'b0}}, qbit};
    acc_nxt = mplier[0] ? (acc + mcand) : acc;
    last    = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.start) begin
      state_nxt = (bus.in1 == '0 || bus.in2 == '0) ? FIN : GCD;
    end else begin
      case (state)
        GCD:     if (b == '0) state_nxt = DIV;
        DIV:     if (last)    state_nxt = MUL;
        MUL:     if (last)    state_nxt = IDLE;
        FIN:                  state_nxt = IDLE;
        default:              state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op1      <= '0;
      op2      <= '0;
      a        <= '0;
      b        <= '0;
      g        <= '0;
      rem      <= '0;
      dvd      <= '0;
      q        <= '0;
      mplier   <= '0;
      mcand    <= '0;
      acc      <= '0;
      cnt      <= '0;
      bus.lcm  <= '0;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
    end else if (bus.start) begin
      // a new start aborts whatever is running; lcm keeps the last result
      op1      <= bus.in1;
      op2      <= bus.in2;
      a        <= bus.in1;
      b        <= bus.in2;
      cnt      <= '0;
      bus.done <= 1'b0;
      bus.busy <= 1'b1;
    end else begin
      case (state)
        GCD: begin
          if (b != '0) begin
            a <= b;
            b <= a % b;
          end else begin
            g   <= a;
            rem <= '0;
            dvd <= op1;
            q   <= '0;
            cnt <= '0;
          end
        end
        DIV: begin
          rem <= qbit ? diff : trial[N-1:0];
          dvd <= dvd << 1;
          q   <= q_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            mplier <= q_nxt;
            mcand  <= {{N{1'b0}}, op2};
            acc    <= '0;
            cnt    <= '0;
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) begin
            bus.lcm  <= acc_nxt;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end
        end
        FIN: begin
          bus.lcm  <= '0;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lcm_seq.sv
// Directed bench for lcm_seq with hand-computed results and edge-exact latencies.
module tb_lcm_seq;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  lcm_if #(.N(N)) bus ();

  lcm_seq #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [N-1:0] x, input logic [N-1:0] y);
    bus.start = 1'b1;
    bus.in1   = x;
    bus.in2   = y;
    tick();
    bus.start = 1'b0;
  endtask

  // Count edges until done; lcm must hold prev until then and busy/done never overlap.
  task automatic wait_done(input string tag, input logic [2*N-1:0] exp_lcm,
                           input int exp_lat, input logic [2*N-1:0] prev);
    int got_lat  = 0;
    int held_err = 0;
    int overlap  = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (bus.busy && bus.done) overlap++;
      if (bus.done) begin
        got_lat = k;
        break;
      end
      if (bus.lcm !== prev) held_err++;
    end
    check_eq({tag, "_latency"}, got_lat, exp_lat);
    check_eq({tag, "_lcm"}, 32'(bus.lcm), 32'(exp_lcm));
    check_eq({tag, "_busy_low"}, 32'(bus.busy), 0);
    check_eq({tag, "_lcm_held"}, held_err, 0);
    check_eq({tag, "_no_overlap"}, overlap, 0);
  endtask

  task automatic run_vec(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic [2*N-1:0] exp_lcm, input int exp_lat);
    logic [2*N-1:0] prev;
    prev = bus.lcm;
    do_start(x, y);
    check_eq({tag, "_busy_set"}, 32'(bus.busy), 1);
    check_eq({tag, "_done_clr"}, 32'(bus.done), 0);
    wait_done(tag, exp_lcm, exp_lat, prev);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_lcm", 32'(bus.lcm), 0);
    check_eq("rst_done", 32'(bus.done), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);

    // latency = E + 2N + 1, E = Euclid steps with b != 0
    run_vec("v12_18", 8'd12, 8'd18, 16'd36, 20);
    run_vec("v0_5", 8'd0, 8'd5, 16'd0, 1);
    run_vec("v9_0", 8'd9, 8'd0, 16'd0, 1);
    run_vec("v255_254", 8'd255, 8'd254, 16'd64770, 19);
    run_vec("v7_7", 8'd7, 8'd7, 16'd7, 18);

    // restart mid-computation: 4/6 takes 3 Euclid steps
    do_start(8'd12, 8'd18);
    for (int i = 0; i < 4; i++) tick();
    check_eq("abort_done_low", 32'(bus.done), 0);
    check_eq("abort_lcm_held", 32'(bus.lcm), 7);
    do_start(8'd4, 8'd6);
    wait_done("abort", 16'd12, 20, 16'd7);

    // reset mid-operation
    do_start(8'd12, 8'd18);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_lcm", 32'(bus.lcm), 0);
    check_eq("midrst_done", 32'(bus.done), 0);
    check_eq("midrst_busy", 32'(bus.busy), 0);
    for (int i = 0; i < 40; i++) tick();
    check_eq("midrst_idle_done", 32'(bus.done), 0);
    check_eq("midrst_idle_busy", 32'(bus.busy), 0);

    // reset and start on the same edge
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.in1   = 8'd3;
    bus.in2   = 8'd5;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    check_eq("rst_wins_busy", 32'(bus.busy), 0);
    check_eq("rst_wins_done", 32'(bus.done), 0);
    for (int i = 0; i < 30; i++) tick();
    check_eq("rst_wins_no_done", 32'(bus.done), 0);

    // start held for three edges: only the last pair (5,3; E=3) counts
    bus.start = 1'b1;
    bus.in1 = 8'd8;  bus.in2 = 8'd12; tick();
    bus.in1 = 8'd20; bus.in2 = 8'd30; tick();
    bus.in1 = 8'd5;  bus.in2 = 8'd3;  tick();
    bus.start = 1'b0;
    check_eq("hold_busy", 32'(bus.busy), 1);
    wait_done("hold", 16'd15, 20, 16'd0);

    // inputs wiggle with start low: result untouched
    for (int i = 0; i < 10; i++) begin
      bus.in1 = 8'(i * 17 + 3);
      bus.in2 = 8'(i * 29 + 1);
      tick();
    end
    check_eq("idle_lcm", 32'(bus.lcm), 15);
    check_eq("idle_done", 32'(bus.done), 1);
    check_eq("idle_busy", 32'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
